// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words, MSB first.
// word_valid/word are combinational on the 4th byte so the caller can
// register the write in the following cycle.
module byte_word_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] pack;
  logic [1:0]  cnt;

  // Shift accepted bytes in and count position within the word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pack <= '0;
      cnt  <= '0;
    end else if (byte_valid) begin
      pack <= {pack[15:0], data};
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {pack, data};

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: receives a length-prefixed image over a byte stream and
// writes it into instruction memory, holding the CPU in reset until done.
// Optional trailing XOR checksum enabled by defining INST_LOADER_CSUM_EN.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ROM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  state_t           state, state_next;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_rx;
  logic             len_ok;
  logic             clear;
  logic             byte_accept;
  logic             word_valid;
  logic [31:0]      word;
  logic             last_word;

  assign len_rx      = {len_hi, rx_data};
  assign len_ok      = (len_rx != '0) && (32'(len_rx) <= ROM_SIZE);
  assign clear       = start && (state inside {IDLE, DONE, ERR});
  assign byte_accept = rx_valid && (state == DATA);
  assign last_word   = word_valid && (word_count == len - 16'd1);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .byte_valid (byte_accept),
    .data       (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef INST_LOADER_CSUM_EN
  logic [7:0] csum;

  // XOR of data bytes only; length bytes are excluded.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      csum <= '0;
    end else if (byte_accept) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LEN_HI;
      LEN_HI: if (rx_valid) state_next = LEN_LO;
      LEN_LO: if (rx_valid) state_next = len_ok ? DATA : ERR;
      DATA: begin
        if (last_word) begin
`ifdef INST_LOADER_CSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
      CSUM: begin
`ifdef INST_LOADER_CSUM_EN
        if (rx_valid) state_next = (rx_data == csum) ? DONE : ERR;
`else
        state_next = ERR;
`endif
      end
      DONE:   if (start) state_next = LEN_HI;
      ERR:    if (start) state_next = LEN_HI;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs; status flags follow the next state so they change
  // in the same cycle as the final write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      len_hi     <= '0;
      len        <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= word_valid;
      if (word_valid) begin
        wr_addr    <= {14'd0, word_count, 2'b00};
        wr_data    <= word;
        word_count <= word_count + 16'd1;
      end else if (clear) begin
        word_count <= '0;
      end
      if (state == LEN_HI && rx_valid) len_hi <= rx_data;
      if (state == LEN_LO && rx_valid) len    <= len_rx;
      cpu_hold <= (state_next != DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
    end
  end

endmodule
